pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Pipeline stall/flush sequencer for the 5-stage RV32I core. It takes the hazard unit's load-use stall, the execute-stage branch/jump redirect, and the instruction/data memory ready signals, and decides which of these wins each cycle. It drives the per-stage stall (enable-low) and flush (bubble) controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also sequences pipeline initialisation after reset, runs a data-memory wait watchdog, and keeps saturating stall/flush performance counters.

## Interface
Parameters:
- INIT_CYCLES, 4, cycles the pipeline is held flushed after reset release; legal range ≥1.
- WAIT_LIMIT, 255, maximum consecutive data-memory wait cycles before a fault; legal range ≥1.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- stall_lu  in  1  load-use stall request from the hazard unit.
- branch_e  in  1  taken branch/jump resolved in E (PC redirect this cycle).
- imem_ready  in  1  instruction fetch data valid this cycle.
- dmem_req_m  in  1  load/store in M this cycle.
- dmem_ready  in  1  data memory completes the M access this cycle.
- StallF, StallD, StallE, StallM  out  1 each  hold the PC / IF-ID / ID-EX / EX-MEM register.
- FlushD, FlushE, FlushW  out  1 each  load a bubble into IF-ID / ID-EX / MEM-WB.
- fault  out  1  sticky watchdog fault.
- stall_cycles  out  CNT_W  count of cycles with StallF=1.
- flush_events  out  CNT_W  count of cycles with branch-caused FlushE.

## Operation
States: INIT, RUN, DWAIT, FAULT. Reset enters INIT with init_cnt=0, wait_cnt=0, fault=0, and both counters at 0.

Stall/flush outputs are Mealy: combinational from the current state and inputs. Any output not listed below is 0.

INIT:
- Outputs: StallF=1, FlushD=1, FlushE=1, FlushW=1.
- init_cnt increments each cycle. When init_cnt==INIT_CYCLES-1, the next state is RUN.

RUN, evaluated in strict priority order:
1. dmem_req_m && !dmem_ready:
   - Outputs: StallF=StallD=StallE=StallM=1, FlushW=1.
   - Next state DWAIT, wait_cnt←1.
   - branch_e and stall_lu are ignored this cycle; the frozen E instruction re-presents them later.
2. branch_e:
   - Outputs: FlushD=1, FlushE=1. The PC takes the target because StallF=0.
   - stall_lu and imem_ready are ignored.
3. stall_lu:
   - Outputs: StallF=1, StallD=1, FlushE=1.
4. !imem_ready:
   - Outputs: StallF=1, FlushD=1.
5. Otherwise all outputs are 0.

DWAIT:
- While !dmem_ready: same freeze outputs as RUN rule 1, and wait_cnt increments.
- If wait_cnt==WAIT_LIMIT and still !dmem_ready, the next state is FAULT.
- On the dmem_ready=1 cycle: no freeze, the RUN priority rules 2–5 apply, the next state is RUN, and wait_cnt←0.

FAULT:
- Outputs: StallF=StallD=StallE=StallM=1, FlushW=1, fault=1.
- The state is held until rst.

Counters:
- stall_cycles increments in every cycle with StallF=1, in any state.
- flush_events increments only when RUN/DWAIT rule 2 fires.
- Both counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- Reset values: state=INIT, fault=0, counters=0. While rst is high the outputs are StallF=1, FlushD=1, FlushE=1, FlushW=1, and all other outputs are 0.
- Reset is asynchronous. Asserting it mid-DWAIT or mid-FAULT immediately forces INIT outputs and clears fault.
- INIT lasts exactly INIT_CYCLES rising edges after rst falls. The first RUN cycle is cycle INIT_CYCLES.
- Zero-cycle control latency: the response appears in the same cycle as the input.
- Maximum DWAIT freeze before FAULT is WAIT_LIMIT cycles. FAULT is entered on the edge ending wait cycle WAIT_LIMIT.
- Simultaneous branch_e and stall_lu: flush wins and there is no stall.
- Simultaneous dmem stall and branch_e: the freeze wins and the branch is serviced on the release cycle.

## Test plan
- Reset then idle (all requests 0, readies 1), INIT_CYCLES=4:
  - Cycles 0–3: StallF=FlushD=FlushE=FlushW=1.
  - Cycle 4: all outputs 0.
  - stall_cycles=4.
- stall_lu=1 for 1 cycle in RUN:
  - That cycle: StallF=StallD=FlushE=1.
  - Next cycle: all 0.
  - stall_cycles +1, flush_events unchanged.
- branch_e=1 together with stall_lu=1 and imem_ready=0:
  - That cycle: FlushD=FlushE=1, StallF=0.
  - flush_events +1.
- dmem_req_m=1 with dmem_ready=0 for 3 cycles, then 1, with branch_e=1 throughout:
  - 3 freeze cycles (StallF..StallM=1, FlushW=1).
  - 4th cycle: FlushD=FlushE=1, no stalls.
  - flush_events +1.
- WAIT_LIMIT=8, dmem_ready stuck at 0:
  - 8 freeze cycles, then fault=1 on the next cycle, held for 20 further cycles.
  - rst pulse clears fault and returns to INIT.
- CNT_W=4, stall_lu held high for 20 cycles: stall_cycles reaches 15 (after INIT contributions) and stays at 15, with no wrap.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage RV32I pipeline.
// Resolves the load-use stall, the E-stage redirect and the memory ready signals into
// per-stage stall/flush controls. It also holds the pipeline flushed after reset, runs a
// data-memory wait watchdog and keeps saturating performance counters.
module pipeline_ctrl #(
    parameter int INIT_CYCLES = 4,
    parameter int WAIT_LIMIT  = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_lu,
    input  logic             branch_e,
    input  logic             imem_ready,
    input  logic             dmem_req_m,
    input  logic             dmem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             fault,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int WW = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_DWAIT = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     init_cnt_q, init_cnt_d;
    // Number of wait cycles already completed in the current data-memory stall.
    logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]  flush_events_q, flush_events_d;
    logic              branch_fire;

    // State, sequencing counters and performance counters; reset forces INIT at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_INIT;
            init_cnt_q     <= '0;
            wait_cnt_q     <= '0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q        <= state_d;
            init_cnt_q     <= init_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    // Next state: INIT countdown, entry into and release from the dmem wait, watchdog trip.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_INIT: begin
                if (init_cnt_q == IW'(INIT_CYCLES - 1)) begin
                    state_d    = S_RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + IW'(1);
                end
            end
            S_RUN: begin
                if (dmem_req_m && !dmem_ready) begin
                    // This cycle is already the first wait cycle of the stall.
                    wait_cnt_d = WW'(1);
                    state_d    = (WAIT_LIMIT == 1) ? S_FAULT : S_DWAIT;
                end
            end
            S_DWAIT: begin
                if (!dmem_ready) begin
                    // The current cycle is wait cycle wait_cnt_q+1; trip after cycle WAIT_LIMIT.
                    if (wait_cnt_q == WW'(WAIT_LIMIT - 1)) begin
                        state_d = S_FAULT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WW'(1);
                    end
                end else begin
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    // Mealy stall/flush outputs: freeze beats redirect, redirect beats load-use, then fetch miss.
    always_comb begin
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        StallM      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        FlushW      = 1'b0;
        fault       = 1'b0;
        branch_fire = 1'b0;
        case (state_q)
            S_INIT: begin
                StallF = 1'b1;
                FlushD = 1'b1;
                FlushE = 1'b1;
                FlushW = 1'b1;
            end
            S_RUN, S_DWAIT: begin
                if ((state_q == S_RUN) ? (dmem_req_m && !dmem_ready) : !dmem_ready) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    StallM = 1'b1;
                    FlushW = 1'b1;
                end else if (branch_e) begin
                    FlushD      = 1'b1;
                    FlushE      = 1'b1;
                    branch_fire = 1'b1;
                end else if (stall_lu) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end else if (!imem_ready) begin
                    StallF = 1'b1;
                    FlushD = 1'b1;
                end
            end
            default: begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
                fault  = 1'b1;
            end
        endcase
    end

    // Saturating performance counters: stalled-fetch cycles and redirect flushes.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (StallF && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        if (branch_fire && (flush_events_q != {CNT_W{1'b1}})) begin
            flush_events_d = flush_events_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed literal checks plus randomized traffic against a
// rule-level model. A second instance with 4-bit counters exercises counter saturation.
module tb_pipeline_ctrl;

    localparam int INIT_C = 4;
    localparam int WLIM   = 8;

    // Output bundle order: {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    localparam logic [6:0] OUT_INIT = 7'b1000111;
    localparam logic [6:0] OUT_FRZ  = 7'b1111001;
    localparam logic [6:0] OUT_BR   = 7'b0000110;
    localparam logic [6:0] OUT_LU   = 7'b1100010;
    localparam logic [6:0] OUT_IM   = 7'b1000100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall_lu = 1'b0, branch_e = 1'b0, imem_ready = 1'b1;
    logic dmem_req_m = 1'b0, dmem_ready = 1'b1;

    logic sf, sd, se, sm, fd, fe, fw, flt;
    logic [15:0] sc, fc;
    logic s_sf, s_sd, s_se, s_sm, s_fd, s_fe, s_fw, s_flt;
    logic [3:0] s_sc, s_fc;
    logic [6:0] outs, s_outs;

    assign outs   = {sf, sd, se, sm, fd, fe, fw};
    assign s_outs = {s_sf, s_sd, s_se, s_sm, s_fd, s_fe, s_fw};

    pipeline_ctrl #(.INIT_CYCLES(INIT_C), .WAIT_LIMIT(WLIM), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall_lu(stall_lu), .branch_e(branch_e),
        .imem_ready(imem_ready), .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
        .StallF(sf), .StallD(sd), .StallE(se), .StallM(sm),
        .FlushD(fd), .FlushE(fe), .FlushW(fw), .fault(flt),
        .stall_cycles(sc), .flush_events(fc)
    );

    pipeline_ctrl #(.INIT_CYCLES(INIT_C), .WAIT_LIMIT(WLIM), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .stall_lu(stall_lu), .branch_e(branch_e),
        .imem_ready(imem_ready), .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
        .StallF(s_sf), .StallD(s_sd), .StallE(s_se), .StallM(s_sm),
        .FlushD(s_fd), .FlushE(s_fe), .FlushW(s_fw), .fault(s_flt),
        .stall_cycles(s_sc), .flush_events(s_fc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    endtask

    function automatic longint sat(input longint v, input longint maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Model state: cycles since reset release, consecutive wait cycles, fault latch, counts.
    int     m_age   = 0;
    int     m_wait  = 0;
    bit     m_fault = 1'b0;
    longint m_stall = 0;
    longint m_flush = 0;

    // Compare every cycle at the falling edge, then advance the model for the coming edge.
    always @(negedge clk) begin : compare
        logic [6:0] e;
        bit br, fz, ef;
        e = 7'b0; br = 1'b0; fz = 1'b0; ef = 1'b0;
        if (rst || m_age < INIT_C) begin
            e = OUT_INIT;
        end else if (m_fault) begin
            e = OUT_FRZ; ef = 1'b1;
        end else begin
            fz = (m_wait > 0) ? !dmem_ready : (dmem_req_m && !dmem_ready);
            if (fz)              e = OUT_FRZ;
            else if (branch_e) begin e = OUT_BR; br = 1'b1; end
            else if (stall_lu)   e = OUT_LU;
            else if (!imem_ready) e = OUT_IM;
        end
        chk("m_outs", longint'(outs), longint'(e));
        chk("m_fault", longint'(flt), longint'(ef));
        chk("m_stall_cycles", longint'(sc), rst ? 0 : sat(m_stall, 65535));
        chk("m_flush_events", longint'(fc), rst ? 0 : sat(m_flush, 65535));
        chk("m_s_outs", longint'({s_outs, s_flt}), longint'({e, ef}));
        chk("m_s_stall_cycles", longint'(s_sc), rst ? 0 : sat(m_stall, 15));
        chk("m_s_flush_events", longint'(s_fc), rst ? 0 : sat(m_flush, 15));
        if (rst) begin
            m_age = 0; m_wait = 0; m_fault = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            if (e[6]) m_stall++;
            if (br) m_flush++;
            if (m_age >= INIT_C && !m_fault) begin
                if (fz) begin
                    m_wait++;
                    if (m_wait >= WLIM) m_fault = 1'b1;
                end else begin
                    m_wait = 0;
                end
            end
            if (m_age < INIT_C) m_age++;
        end
    end

    task automatic set_in(input bit lu, input bit br, input bit im, input bit dq, input bit dr);
        stall_lu = lu; branch_e = br; imem_ready = im; dmem_req_m = dq; dmem_ready = dr;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int burst;

    initial begin
        set_in(0, 0, 1, 0, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_outs", longint'(outs), longint'(OUT_INIT));
        chk("rst_fault", longint'(flt), 0);
        chk("rst_stall_cycles", longint'(sc), 0);
        tick;
        rst = 1'b0;
        for (int i = 0; i < INIT_C; i++) begin
            @(negedge clk);
            chk("init_outs", longint'(outs), longint'(OUT_INIT));
            tick;
        end
        @(negedge clk);
        chk("first_run_outs", longint'(outs), 0);
        chk("init_stall_cycles", longint'(sc), 4);
        tick;
        // Single load-use stall
        set_in(1, 0, 1, 0, 1);
        @(negedge clk);
        chk("lu_outs", longint'(outs), longint'(OUT_LU));
        tick;
        set_in(0, 0, 1, 0, 1);
        @(negedge clk);
        chk("after_lu_outs", longint'(outs), 0);
        chk("lu_stall_cycles", longint'(sc), 5);
        chk("lu_flush_events", longint'(fc), 0);
        tick;
        // Branch beats load-use and fetch miss
        set_in(1, 1, 0, 0, 1);
        @(negedge clk);
        chk("br_lu_outs", longint'(outs), longint'(OUT_BR));
        tick;
        set_in(0, 0, 1, 0, 1);
        @(negedge clk);
        chk("br_flush_events", longint'(fc), 1);
        tick;
        // Data wait with branch pending: freeze three cycles, branch on release
        set_in(0, 1, 1, 1, 0);
        repeat (3) begin
            @(negedge clk);
            chk("dwait_outs", longint'(outs), longint'(OUT_FRZ));
            tick;
        end
        set_in(0, 1, 1, 1, 1);
        @(negedge clk);
        chk("dwait_release_outs", longint'(outs), longint'(OUT_BR));
        tick;
        set_in(0, 0, 1, 0, 1);
        @(negedge clk);
        chk("dwait_flush_events", longint'(fc), 2);
        chk("dwait_stall_cycles", longint'(sc), 8);
        tick;
        // Watchdog: WLIM freeze cycles, then sticky fault
        set_in(0, 0, 1, 1, 0);
        repeat (WLIM) begin
            @(negedge clk);
            chk("wd_freeze_outs", longint'(outs), longint'(OUT_FRZ));
            chk("wd_no_fault", longint'(flt), 0);
            tick;
        end
        set_in(0, 0, 1, 0, 1);
        repeat (21) begin
            @(negedge clk);
            chk("wd_fault", longint'(flt), 1);
            chk("wd_fault_outs", longint'(outs), longint'(OUT_FRZ));
            tick;
        end
        // Asynchronous reset mid-FAULT takes effect before any clock edge
        rst = 1'b1;
        #1;
        chk("arst_fault", longint'(flt), 0);
        chk("arst_outs", longint'(outs), longint'(OUT_INIT));
        chk("arst_stall_cycles", longint'(sc), 0);
        tick;
        rst = 1'b0;
        // Counter saturation on the 4-bit instance: 4 INIT + 20 load-use cycles
        set_in(1, 0, 1, 0, 1);
        repeat (24) tick;
        @(negedge clk);
        chk("sat_stall_cycles_4b", longint'(s_sc), 15);
        chk("nosat_stall_cycles_16b", longint'(sc), 24);
        tick;
        // Randomized traffic with occasional long data waits and resets
        burst = 0;
        repeat (3000) begin
            rst = ($urandom_range(0, 299) == 0);
            stall_lu   = ($urandom_range(0, 3) == 0);
            branch_e   = ($urandom_range(0, 4) == 0);
            imem_ready = ($urandom_range(0, 4) != 0);
            dmem_req_m = ($urandom_range(0, 2) == 0);
            if (burst > 0) begin
                dmem_ready = 1'b0;
                burst--;
            end else begin
                if ($urandom_range(0, 39) == 0) burst = $urandom_range(5, 12);
                dmem_ready = ($urandom_range(0, 3) != 0);
            end
            tick;
        end
        rst = 1'b0;
        set_in(0, 0, 1, 0, 1);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
